// File: rtl/elevator_pkg.sv
// Shared constants, sweep encoding and small helpers for the call register.
package elevator_pkg;

    localparam logic [1:0] FLR_GROUND  = 2'd0;
    localparam logic [1:0] FLR_FIRST   = 2'd1;
    localparam logic [1:0] FLR_SECOND  = 2'd2;
    localparam logic [1:0] FLR_INVALID = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } sweep_e;

    localparam int SYNC_STAGES_DEF     = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 4;

    // Request bit positions inside the 7-bit request vector.
    localparam int NUM_BTNS     = 7;
    localparam int R_GND_UP     = 0;
    localparam int R_FIRST_UP   = 1;
    localparam int R_FIRST_DWN  = 2;
    localparam int R_SECOND_DWN = 3;
    localparam int R_CAR_GND    = 4;
    localparam int R_CAR_FIRST  = 5;
    localparam int R_CAR_SECOND = 6;

    function automatic logic [2:0] popcount7(input logic [6:0] v);
        logic [2:0] c;
        c = '0;
        for (int i = 0; i < 7; i++) c = c + {2'b00, v[i]};
        return c;
    endfunction

    // Returns {found, floor} for the lowest floor set in a 3-bit floor mask.
    function automatic logic [2:0] lowest_flr(input logic [2:0] m);
        if (m[0])      return {1'b1, FLR_GROUND};
        else if (m[1]) return {1'b1, FLR_FIRST};
        else if (m[2]) return {1'b1, FLR_SECOND};
        else           return 3'b000;
    endfunction

    // Returns {found, floor} for the highest floor set in a 3-bit floor mask.
    function automatic logic [2:0] highest_flr(input logic [2:0] m);
        if (m[2])      return {1'b1, FLR_SECOND};
        else if (m[1]) return {1'b1, FLR_FIRST};
        else if (m[0]) return {1'b1, FLR_GROUND};
        else           return 3'b000;
    endfunction

endpackage

// File: rtl/elevator_call_register_button_conditioner.sv
// Per-button conditioning: synchroniser, saturating debounce counter and a
// one-cycle press pulse when the counter first reaches the threshold.
module button_conditioner
    import elevator_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic press_o
);

    localparam logic [3:0] THR = 4'(DEBOUNCE_CYCLES);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [3:0]             cnt_q, cnt_d;
    logic                   at_thr_q;
    logic                   lvl;

    assign lvl = sync_q[SYNC_STAGES-1];

    // Shift the raw button through the synchroniser chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], btn_i};
    end

    // Count consecutive high cycles, saturating at the threshold; any low clears.
    always_comb begin
        cnt_d = '0;
        if (lvl) cnt_d = (cnt_q == THR) ? cnt_q : cnt_q + 4'd1;
    end

    // Counter state plus a one-cycle-late copy of "at threshold" for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            at_thr_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            at_thr_q <= (cnt_q == THR);
        end
    end

    // Held buttons saturate at THR, so this fires exactly once per press.
    assign press_o = (cnt_q == THR) && !at_thr_q;

endmodule

// File: rtl/elevator_call_register.sv
// Call register: latches conditioned button presses, clears them as the car
// services floors, tracks sweep direction and selects the next target floor.
// rst_n is expected to be release-synchronised upstream.
module elevator_call_register
    import elevator_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ground_flr_up_btn,
    input  logic       first_flr_up_btn,
    input  logic       first_flr_dwn_btn,
    input  logic       second_flr_dwn_btn,
    input  logic       go_to_ground_flr,
    input  logic       go_to_first_flr,
    input  logic       go_to_second_flr,
    input  logic [1:0] current_flr,
    input  logic       is_moving,
    input  logic       is_moving_up,
    input  logic       is_moving_dwn,
    input  logic       is_door_close,
    output logic       req_ground_up,
    output logic       req_first_up,
    output logic       req_first_dwn,
    output logic       req_second_dwn,
    output logic       req_car_ground,
    output logic       req_car_first,
    output logic       req_car_second,
    output logic [2:0] pending_cnt,
    output logic [1:0] next_flr,
    output logic       next_valid
);

    logic [NUM_BTNS-1:0] raw_btn, press, clr;
    logic [NUM_BTNS-1:0] req_q, req_d;
    logic [2:0]          pending_q;
    sweep_e              sweep_q, sweep_d;
    logic [1:0]          next_flr_q, next_flr_d;
    logic                next_valid_q, next_valid_d;

    logic [2:0] flr_req, above_m, below_m, at_m, sel;
    logic       any_above, any_below, any_at, svc;

    assign raw_btn = {go_to_second_flr, go_to_first_flr, go_to_ground_flr,
                      second_flr_dwn_btn, first_flr_dwn_btn, first_flr_up_btn,
                      ground_flr_up_btn};

    for (genvar g = 0; g < NUM_BTNS; g++) begin : g_cond
        button_conditioner #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_cond (
            .clk    (clk),
            .rst_n  (rst_n),
            .btn_i  (raw_btn[g]),
            .press_o(press[g])
        );
    end

    // Per-floor view of the latched requests (either hall direction or car).
    assign flr_req[0] = req_q[R_GND_UP]   | req_q[R_CAR_GND];
    assign flr_req[1] = req_q[R_FIRST_UP] | req_q[R_FIRST_DWN] | req_q[R_CAR_FIRST];
    assign flr_req[2] = req_q[R_SECOND_DWN] | req_q[R_CAR_SECOND];

    // Floor masks relative to the current floor; all empty on an invalid floor.
    always_comb begin
        above_m = 3'b000;
        below_m = 3'b000;
        at_m    = 3'b000;
        case (current_flr)
            FLR_GROUND: begin above_m = 3'b110; at_m = 3'b001; end
            FLR_FIRST:  begin above_m = 3'b100; below_m = 3'b001; at_m = 3'b010; end
            FLR_SECOND: begin below_m = 3'b011; at_m = 3'b100; end
            default: ;
        endcase
    end

    assign any_above = |(flr_req & above_m);
    assign any_below = |(flr_req & below_m);
    assign any_at    = |(flr_req & at_m);
    assign svc       = !is_moving && !is_door_close && (current_flr != FLR_INVALID);

    // Clear requests served at the current floor; first-floor hall calls honour the sweep.
    always_comb begin
        clr = '0;
        if (svc) begin
            case (current_flr)
                FLR_GROUND: begin
                    clr[R_CAR_GND] = 1'b1;
                    clr[R_GND_UP]  = 1'b1;
                end
                FLR_FIRST: begin
                    clr[R_CAR_FIRST] = 1'b1;
                    clr[R_FIRST_UP]  = (sweep_q != DOWN);
                    clr[R_FIRST_DWN] = (sweep_q != UP);
                end
                FLR_SECOND: begin
                    clr[R_CAR_SECOND] = 1'b1;
                    clr[R_SECOND_DWN] = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Clear beats a simultaneous press on the same bit.
    assign req_d = (req_q | press) & ~clr;

    // Request latch and its population count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q     <= '0;
            pending_q <= '0;
        end else begin
            req_q     <= req_d;
            pending_q <= popcount7(req_d);
        end
    end

    // Sweep next state: motion flags win; when stopped, reverse or idle once the
    // current direction has nothing left. An invalid floor freezes the sweep.
    always_comb begin
        sweep_d = sweep_q;
        if (current_flr != FLR_INVALID) begin
            if (is_moving_up && !is_moving_dwn) begin
                sweep_d = UP;
            end else if (is_moving_dwn && !is_moving_up) begin
                sweep_d = DOWN;
            end else if (!is_moving_up && !is_moving_dwn && !is_moving) begin
                case (sweep_q)
                    UP:      if (!any_above) sweep_d = (any_below || any_at) ? DOWN : IDLE;
                    DOWN:    if (!any_below) sweep_d = (any_above || any_at) ? UP : IDLE;
                    default: sweep_d = IDLE;
                endcase
            end
        end
    end

    // Sweep state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sweep_q <= IDLE;
        else        sweep_q <= sweep_d;
    end

    // Target select: continue the sweep if possible, otherwise nearest floor
    // with ties going to the lower floor.
    always_comb begin
        sel = 3'b000;
        if (current_flr != FLR_INVALID) begin
            case (sweep_q)
                UP:      sel = lowest_flr(flr_req & above_m);
                DOWN:    sel = highest_flr(flr_req & below_m);
                default: sel = 3'b000;
            endcase
            if (!sel[2]) begin
                if (current_flr == FLR_SECOND) sel = highest_flr(flr_req);
                else if (any_at)               sel = {1'b1, current_flr};
                else                           sel = lowest_flr(flr_req);
            end
        end
        next_flr_d   = sel[1:0];
        next_valid_d = sel[2];
    end

    // Target registers, one cycle behind the request/sweep state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            next_flr_q   <= FLR_GROUND;
            next_valid_q <= 1'b0;
        end else begin
            next_flr_q   <= next_flr_d;
            next_valid_q <= next_valid_d;
        end
    end

    assign req_ground_up  = req_q[R_GND_UP];
    assign req_first_up   = req_q[R_FIRST_UP];
    assign req_first_dwn  = req_q[R_FIRST_DWN];
    assign req_second_dwn = req_q[R_SECOND_DWN];
    assign req_car_ground = req_q[R_CAR_GND];
    assign req_car_first  = req_q[R_CAR_FIRST];
    assign req_car_second = req_q[R_CAR_SECOND];
    assign pending_cnt    = pending_q;
    assign next_flr       = next_flr_q;
    assign next_valid     = next_valid_q;

endmodule

// File: tb/tb_elevator_call_register.sv
// Directed plus randomized bench for elevator_call_register with a
// floor-level reference model.
module tb_elevator_call_register;

    localparam int S = 2;
    localparam int D = 4;
    // Floor owning each request bit, bench order: gnd_up, 1_up, 1_dwn, 2_dwn, car0, car1, car2.
    localparam int FLR_OF [0:6] = '{0, 1, 1, 2, 0, 1, 2};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ground_flr_up_btn = 0, first_flr_up_btn = 0, first_flr_dwn_btn = 0, second_flr_dwn_btn = 0;
    logic       go_to_ground_flr = 0, go_to_first_flr = 0, go_to_second_flr = 0;
    logic [1:0] current_flr = 2'd2;
    logic       is_moving = 0, is_moving_up = 0, is_moving_dwn = 0, is_door_close = 1;
    logic       req_ground_up, req_first_up, req_first_dwn, req_second_dwn;
    logic       req_car_ground, req_car_first, req_car_second;
    logic [2:0] pending_cnt;
    logic [1:0] next_flr;
    logic       next_valid;

    int errors = 0;
    int checks = 0;

    // Reference model state.
    logic [6:0] m_req;
    int         m_sweep;   // 0 idle, 1 up, 2 down
    logic [1:0] m_next;
    logic       m_valid;
    logic [6:0] hist[$];   // raw button samples, one per clock since reset

    always #5 clk = ~clk;

    elevator_call_register dut (
        .clk(clk), .rst_n(rst_n),
        .ground_flr_up_btn(ground_flr_up_btn), .first_flr_up_btn(first_flr_up_btn),
        .first_flr_dwn_btn(first_flr_dwn_btn), .second_flr_dwn_btn(second_flr_dwn_btn),
        .go_to_ground_flr(go_to_ground_flr), .go_to_first_flr(go_to_first_flr),
        .go_to_second_flr(go_to_second_flr), .current_flr(current_flr),
        .is_moving(is_moving), .is_moving_up(is_moving_up), .is_moving_dwn(is_moving_dwn),
        .is_door_close(is_door_close),
        .req_ground_up(req_ground_up), .req_first_up(req_first_up), .req_first_dwn(req_first_dwn),
        .req_second_dwn(req_second_dwn), .req_car_ground(req_car_ground),
        .req_car_first(req_car_first), .req_car_second(req_car_second),
        .pending_cnt(pending_cnt), .next_flr(next_flr), .next_valid(next_valid)
    );

    function automatic logic [6:0] btn_vec();
        return {go_to_second_flr, go_to_first_flr, go_to_ground_flr, second_flr_dwn_btn,
                first_flr_dwn_btn, first_flr_up_btn, ground_flr_up_btn};
    endfunction

    task automatic set_btns(input logic [6:0] v);
        {go_to_second_flr, go_to_first_flr, go_to_ground_flr, second_flr_dwn_btn,
         first_flr_dwn_btn, first_flr_up_btn, ground_flr_up_btn} = v;
    endtask

    function automatic logic [12:0] dut_vec();
        return {req_car_second, req_car_first, req_car_ground, req_second_dwn, req_first_dwn,
                req_first_up, req_ground_up, pending_cnt, next_flr, next_valid};
    endfunction

    function automatic logic [12:0] model_vec();
        return {m_req, 3'($countones(m_req)), m_next, m_valid};
    endfunction

    function automatic bit raw_at(input int j, input int b);
        if (j < 0) return 1'b0;
        return hist[j][b];
    endfunction

    task automatic chk(input string tag, input logic [12:0] obs, input logic [12:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_req = '0; m_sweep = 0; m_next = 2'd0; m_valid = 1'b0;
        hist.delete();
    endtask

    // One rising edge of the reference model, from the behavioural rules.
    task automatic model_edge();
        logic [6:0] raw, press, clr;
        bit         fr [0:2];
        bit         above, below, at_f, run, found;
        int         F, n, ns, best;
        raw = btn_vec();
        n   = hist.size();
        F   = int'(current_flr);
        // A press lands when the raw level shows a fresh run of exactly D highs,
        // delayed by the synchroniser depth.
        for (int b = 0; b < 7; b++) begin
            run = !raw_at(n - S - D - 1, b);
            for (int j = n - S - D; j <= n - S - 1; j++) if (!raw_at(j, b)) run = 0;
            press[b] = run;
        end
        hist.push_back(raw);
        for (int f = 0; f < 3; f++) fr[f] = 0;
        for (int b = 0; b < 7; b++) if (m_req[b]) fr[FLR_OF[b]] = 1;
        above = 0; below = 0; at_f = 0;
        if (F != 3) for (int f = 0; f < 3; f++) if (fr[f]) begin
            if (f > F) above = 1;
            if (f < F) below = 1;
            if (f == F) at_f = 1;
        end
        clr = '0;
        if (!is_moving && !is_door_close && F != 3)
            for (int b = 0; b < 7; b++) if (FLR_OF[b] == F) begin
                if (b == 1)      clr[b] = (m_sweep != 2);
                else if (b == 2) clr[b] = (m_sweep != 1);
                else             clr[b] = 1'b1;
            end
        ns = m_sweep;
        if (F != 3) begin
            if (is_moving_up && !is_moving_dwn)      ns = 1;
            else if (is_moving_dwn && !is_moving_up) ns = 2;
            else if (!is_moving_up && !is_moving_dwn && !is_moving) begin
                if (m_sweep == 1 && !above)      ns = (below || at_f) ? 2 : 0;
                else if (m_sweep == 2 && !below) ns = (above || at_f) ? 1 : 0;
            end
        end
        found = 0; best = 0;
        if (F != 3) begin
            if (m_sweep == 1) begin
                for (int f = 2; f > F; f--) if (fr[f]) begin found = 1; best = f; end
            end else if (m_sweep == 2) begin
                for (int f = 0; f < F; f++) if (fr[f]) begin found = 1; best = f; end
            end
            if (!found)
                for (int f = 0; f < 3; f++)
                    if (fr[f] && (!found || (f > F ? f - F : F - f) < (best > F ? best - F : F - best))) begin
                        found = 1; best = f;
                    end
        end
        m_next  = found ? 2'(best) : 2'd0;
        m_valid = found;
        m_sweep = ns;
        m_req   = (m_req | press) & ~clr;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("cycle", dut_vec(), model_vec());
    endtask

    // Reset asserted between edges; outputs must clear without a clock.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("reset_async", dut_vec(), 13'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [6:0] bv;
        model_reset();
        #1;
        chk("reset_initial", dut_vec(), 13'd0);
        do_reset();

        // Hall press at floor 0 while idle at floor 2 with door closed.
        ground_flr_up_btn = 1;
        repeat (6) tick();
        chk("gnd_up_edge5", 13'(req_ground_up), 13'd0);
        tick();
        chk("gnd_up_edge6", 13'(req_ground_up), 13'd1);
        repeat (3) tick();
        ground_flr_up_btn = 0;
        tick();
        chk("gnd_target", {8'd0, pending_cnt, next_flr, next_valid}, {8'd0, 3'd1, 2'd0, 1'b1});
        repeat (5) tick();
        chk("gnd_up_held", 13'(req_ground_up), 13'd1);

        // Short glitch rejected; long hold sets once and does not re-set after a clear.
        go_to_first_flr = 1;
        repeat (3) tick();
        go_to_first_flr = 0;
        repeat (8) tick();
        chk("glitch_reject", 13'(req_car_first), 13'd0);
        go_to_first_flr = 1;
        repeat (10) tick();
        chk("hold_set", 13'(req_car_first), 13'd1);
        current_flr = 2'd1; is_door_close = 0;
        repeat (2) tick();
        chk("hold_clear", 13'(req_car_first), 13'd0);
        repeat (8) tick();
        chk("hold_no_reset", 13'(req_car_first), 13'd0);
        go_to_first_flr = 0; is_door_close = 1;
        repeat (2) tick();

        // Both first-floor hall calls; arrive sweeping up.
        current_flr = 2'd0; is_moving = 1; is_moving_up = 1;
        first_flr_up_btn = 1; first_flr_dwn_btn = 1;
        repeat (5) tick();
        first_flr_up_btn = 0; first_flr_dwn_btn = 0;
        repeat (4) tick();
        chk("first_both_set", {11'd0, req_first_dwn, req_first_up}, 13'b11);
        current_flr = 2'd1; is_moving = 0; is_moving_up = 0; is_door_close = 0;
        tick();
        chk("first_up_only", {11'd0, req_first_dwn, req_first_up}, 13'b10);
        tick();
        chk("first_dwn_after", {11'd0, req_first_dwn, req_first_up}, 13'b00);

        // Mid-sweep reset with a car request pending.
        is_door_close = 1; is_moving = 1; is_moving_up = 1;
        go_to_second_flr = 1;
        repeat (5) tick();
        go_to_second_flr = 0;
        repeat (3) tick();
        chk("car2_set", 13'(req_car_second), 13'd1);
        do_reset();

        // Sweep up from floor 0 towards requests at 1 and 2.
        current_flr = 2'd0;
        go_to_first_flr = 1; second_flr_dwn_btn = 1;
        repeat (5) tick();
        go_to_first_flr = 0; second_flr_dwn_btn = 0;
        repeat (3) tick();
        chk("up_target1", {10'd0, next_flr, next_valid}, {10'd0, 2'd1, 1'b1});
        is_moving = 0; is_moving_up = 0;
        repeat (2) tick();
        chk("up_stop_target1", {10'd0, next_flr, next_valid}, {10'd0, 2'd1, 1'b1});
        current_flr = 2'd1; is_door_close = 0;
        repeat (2) tick();
        chk("car1_served", 13'(req_car_first), 13'd0);
        chk("up_target2", {10'd0, next_flr, next_valid}, {10'd0, 2'd2, 1'b1});

        // Invalid floor: nothing clears, no target.
        current_flr = 2'd3;
        repeat (2) tick();
        chk("invalid_flr", {11'd0, req_second_dwn, next_valid}, 13'b10);

        // Press landing while its floor is being serviced: clear wins.
        current_flr = 2'd0;
        ground_flr_up_btn = 1;
        repeat (10) tick();
        chk("clear_wins", 13'(req_ground_up), 13'd0);
        ground_flr_up_btn = 0;
        tick();

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 599) == 0) do_reset();
            bv = btn_vec();
            for (int b = 0; b < 7; b++) if ($urandom_range(0, 5) == 0) bv[b] = ~bv[b];
            set_btns(bv);
            if ($urandom_range(0, 9) == 0) current_flr = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) begin
                is_moving = ~is_moving;
                {is_moving_up, is_moving_dwn} = is_moving ? 2'($urandom_range(0, 3)) : 2'b00;
            end
            if ($urandom_range(0, 3) == 0) is_door_close = ~is_door_close;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
